// File: rtl/ram_uart_dump_pkg.sv
// rtl/ram_uart_dump_pkg.sv - shared FSM states and frame constants for ram_uart_dump
// RAM_UART_DUMP_PARITY_EN selects an 11-bit frame with an even-parity bit.
package ram_uart_dump_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_SEND,
    S_NEXT
  } dump_state_t;

`ifdef RAM_UART_DUMP_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  function automatic int calc_bit_clks(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/ram_uart_dump_tx_core.sv
// rtl/ram_uart_dump_tx_core.sv - fixed-baud byte serialiser (start, D0..D7, stop)
// RAM_UART_DUMP_PARITY_EN inserts an even-parity bit before the stop bit.
module uart_byte_tx_core
  import ram_uart_dump_pkg::*;
#(
  parameter int BIT_CLKS = 434
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       load,
  input  logic [7:0] data,
  output logic       uart_tx,
  output logic       tx_done,
  output logic       tx_busy
);

  localparam int                CNT_W     = $clog2(BIT_CLKS);
  localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(BIT_CLKS - 1);
  localparam logic [3:0]        BIT_LAST  = 4'(FRAME_BITS - 1);

  logic [CNT_W-1:0]      r_baud;
  logic [3:0]            r_bit;
  logic [FRAME_BITS-1:0] r_frame;
  logic                  r_busy;
  logic [FRAME_BITS-1:0] w_frame;
  logic                  w_bit_end;

`ifdef RAM_UART_DUMP_PARITY_EN
  assign w_frame = {1'b1, ^data, data, 1'b0};
`else
  assign w_frame = {1'b1, data, 1'b0};
`endif

  assign w_bit_end = r_busy && (r_baud == BAUD_LAST);
  assign tx_done   = w_bit_end && (r_bit == BIT_LAST);
  assign tx_busy   = r_busy;
  // Idle-high comes from r_busy, so an async reset forces the line high at once.
  assign uart_tx   = r_busy ? r_frame[0] : 1'b1;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_baud  <= '0;
      r_bit   <= '0;
      r_frame <= '0;
      r_busy  <= 1'b0;
    end else if (load) begin
      r_baud  <= '0;
      r_bit   <= '0;
      r_frame <= w_frame;
      r_busy  <= 1'b1;
    end else if (r_busy) begin
      if (w_bit_end) begin
        r_baud <= '0;
        if (r_bit == BIT_LAST) begin
          r_busy <= 1'b0;
        end else begin
          r_bit   <= r_bit + 4'd1;
          r_frame <= {1'b1, r_frame[FRAME_BITS-1:1]};
        end
      end else begin
        r_baud <= r_baud + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_uart_dump.sv
// rtl/ram_uart_dump.sv - dumps a RAM byte range to the host as UART frames
// RAM_UART_DUMP_PARITY_EN (via the package and serialiser) adds even parity.
module ram_uart_dump
  import ram_uart_dump_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200,
  parameter int ADDR_W   = 16
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] length,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [7:0]        ram_rd_data,
  output logic              uart_tx,
  output logic              busy,
  output logic              done
);

  localparam int BIT_CLKS = calc_bit_clks(CLK_FREQ, BAUD);

  dump_state_t       r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_count;
  logic              r_busy;
  logic              r_done;
  logic              w_load;
  logic              w_tx_done;
  logic              w_tx_busy;
  logic              w_last;

  assign w_last      = (r_count == ADDR_W'(1));
  assign ram_rd_en   = (r_state == S_RD_REQ);
  assign ram_rd_addr = r_addr;
  assign busy        = r_busy;
  assign done        = r_done;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE:    if (start && (length != '0)) w_state_nxt = S_RD_REQ;
      S_RD_REQ:  w_state_nxt = S_RD_WAIT;
      S_RD_WAIT: begin
        w_load      = 1'b1;
        w_state_nxt = S_SEND;
      end
      S_SEND:    if (w_tx_done && w_tx_busy) w_state_nxt = S_NEXT;
      S_NEXT:    w_state_nxt = w_last ? S_IDLE : S_RD_REQ;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_addr  <= '0;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (length != '0) begin
              r_addr  <= start_addr;
              r_count <= length;
              r_busy  <= 1'b1;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        // Address increments unconditionally and wraps at 2^ADDR_W.
        S_NEXT: begin
          r_addr  <= r_addr + 1'b1;
          r_count <= r_count - 1'b1;
          if (w_last) begin
            r_done <= 1'b1;
            r_busy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  uart_byte_tx_core #(
    .BIT_CLKS(BIT_CLKS)
  ) u_tx (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .load   (w_load),
    .data   (ram_rd_data),
    .uart_tx(uart_tx),
    .tx_done(w_tx_done),
    .tx_busy(w_tx_busy)
  );

endmodule

// File: tb/tb_ram_uart_dump.sv
// tb/tb_ram_uart_dump.sv - scoreboard bench for ram_uart_dump (RAM_UART_DUMP_PARITY_EN aware)
`timescale 1ns/1ps
module tb_ram_uart_dump;

  localparam int BIT_CLKS  = 50_000_000 / 115200;
`ifdef RAM_UART_DUMP_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int DUMP_CLKS = FB * BIT_CLKS + 3;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] start_addr = '0;
  logic [15:0] length = '0;
  logic        ram_rd_en;
  logic [15:0] ram_rd_addr;
  logic [7:0]  ram_rd_data;
  logic        uart_tx, busy, done;

  logic [7:0] mem [0:65535];
  int exp_addr_q[$];
  int exp_byte_q[$];
  int total = 0, bad = 0;
  int frames = 0, rd_cnt = 0, done_cnt = 0, tx_low_cnt = 0, busy_cnt = 0, rst_epoch = 0;

  always #10 Clk = ~Clk;

  ram_uart_dump dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .ram_rd_en  (ram_rd_en),
    .ram_rd_addr(ram_rd_addr),
    .ram_rd_data(ram_rd_data),
    .uart_tx    (uart_tx),
    .busy       (busy),
    .done       (done)
  );

  always @(posedge Clk) if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(negedge Reset_n) rst_epoch++;

  always @(negedge Clk) begin
    if (Reset_n) begin
      if (done) done_cnt++;
      if (busy) busy_cnt++;
      if (!uart_tx) tx_low_cnt++;
      if (ram_rd_en) begin
        rd_cnt++;
        if (exp_addr_q.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
        else check("rd_addr", 32'(ram_rd_addr), 32'(exp_addr_q.pop_front()));
      end
    end
  end

  task automatic rx_frame();
    logic [FB-1:0] early, late;
    logic [7:0]    eb;
    int            ep;
    ep = rst_epoch;
    early = '0;
    late  = '0;
    for (int c = 1; c < FB * BIT_CLKS; c++) begin
      @(posedge Clk);
      #1;
      if (c % BIT_CLKS == 1)            early[c / BIT_CLKS] = uart_tx;
      if (c % BIT_CLKS == BIT_CLKS - 1) late[c / BIT_CLKS]  = uart_tx;
    end
    if (ep == rst_epoch) begin
      frames++;
      if (exp_byte_q.size() == 0) begin
        check("rx_unexpected", 32'd1, 32'd0);
      end else begin
        eb = 8'(exp_byte_q.pop_front());
        check("rx_start", 32'({early[0], late[0]}), 32'd0);
        check("rx_stop", 32'({early[FB-1], late[FB-1]}), 32'd3);
        check("rx_byte_early", 32'(early[8:1]), 32'(eb));
        check("rx_byte_late", 32'(late[8:1]), 32'(eb));
`ifdef RAM_UART_DUMP_PARITY_EN
        check("rx_parity", 32'({early[9], late[9]}), (^eb) ? 32'd3 : 32'd0);
`endif
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge uart_tx);
      if (Reset_n) rx_frame();
    end
  end

  task automatic run_dump(input logic [15:0] a, input logic [15:0] n, input string tag);
    int cyc, want, dc0;
    for (int i = 0; i < int'(n); i++) begin
      exp_addr_q.push_back(int'(16'(a + 16'(i))));
      exp_byte_q.push_back(int'(mem[16'(a + 16'(i))]));
    end
    want = int'(n) * DUMP_CLKS;
    dc0  = done_cnt;
    @(negedge Clk);
    start_addr = a;
    length     = n;
    start      = 1'b1;
    cyc = 0;
    forever begin
      @(posedge Clk);
      #1;
      if (cyc == 0) start = 1'b0;
      if (done || cyc > want + 50) break;
      cyc++;
    end
    check({tag, "_done_cycle"}, 32'(cyc), 32'(want));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    repeat (10) @(posedge Clk);
    #1;
    check({tag, "_done_pulses"}, 32'(done_cnt - dc0), 32'd1);
  endtask

  initial begin
    int f0, rd0, tl0, b0;
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, rd0, tl0, b0;
    mem[16'h0010] = 8'h5A; mem[16'h0011] = 8'h43; mem[16'h0012] = 8'h78;
    mem[16'hFFFF] = 8'h9A; mem[16'h0000] = 8'hBC;
    mem[16'h0200] = 8'h01; mem[16'h0201] = 8'h80; mem[16'h0202] = 8'hFF; mem[16'h0203] = 8'h00;
    mem[16'h0100] = 8'hDE;

    repeat (3) @(posedge Clk);
    #1;
    check("rst_tx", 32'(uart_tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rd_en", 32'(ram_rd_en), 32'd0);
    check("rst_rd_addr", 32'(ram_rd_addr), 32'd0);
    @(negedge Clk) Reset_n = 1'b1;
    repeat (5) @(posedge Clk);

    f0 = frames;
    run_dump(16'h0010, 16'd3, "t1");
    check("t1_frames", 32'(frames - f0), 32'd3);

    rd0 = rd_cnt; tl0 = tx_low_cnt; b0 = busy_cnt;
    run_dump(16'h0040, 16'd0, "t2");
    check("t2_rd_en", 32'(rd_cnt - rd0), 32'd0);
    check("t2_tx_low", 32'(tx_low_cnt - tl0), 32'd0);
    check("t2_busy", 32'(busy_cnt - b0), 32'd0);

    f0 = frames;
    run_dump(16'hFFFF, 16'd2, "t3");
    check("t3_frames", 32'(frames - f0), 32'd2);

    f0 = frames;
    fork
      run_dump(16'h0200, 16'd4, "t4");
      begin
        repeat (1001) @(posedge Clk);
        @(negedge Clk);
        start_addr = 16'h0300;
        length     = 16'd5;
        start      = 1'b1;
        @(negedge Clk);
        start = 1'b0;
      end
    join
    check("t4_frames", 32'(frames - f0), 32'd4);

    f0 = frames;
    exp_addr_q.push_back(16'h0100);
    @(negedge Clk);
    start_addr = 16'h0100;
    length     = 16'd1;
    start      = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    repeat (2 + BIT_CLKS + 200) @(posedge Clk);
    #1;
    check("t5_pre_tx_d0", 32'(uart_tx), 32'd0);
    #4;
    Reset_n = 1'b0;
    #1;
    check("t5_rst_tx", 32'(uart_tx), 32'd1);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_done", 32'(done), 32'd0);
    #49;
    Reset_n = 1'b1;
    repeat (5000) @(posedge Clk);
    run_dump(16'h0100, 16'd1, "t5");
    check("t5_frames", 32'(frames - f0), 32'd1);

`ifdef RAM_UART_DUMP_PARITY_EN
    run_dump(16'h0010, 16'd1, "t6a");
    run_dump(16'h0011, 16'd1, "t6b");
`endif

    repeat (20) @(posedge Clk);
    check("addr_q_left", 32'(exp_addr_q.size()), 32'd0);
    check("byte_q_left", 32'(exp_byte_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_uart_dump.md
Name: ram_uart_dump

Overview:
Reads a block of bytes from the frame/pixel RAM read port and sends them back to the host over the UART line as 8N1 frames. It is the return path of the UART→RAM→TFT chain and lets the host read back what it wrote. It is driven by a one-cycle start pulse with a start address and byte count. It contains a fixed-baud serialiser sub-module.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD, 115200, line rate; bit period BIT_CLKS = CLK_FREQ/BAUD (integer division) = 434 clocks
ADDR_W, 16, RAM address width

Ports:
Clk  in  1  system clock, rising edge
Reset_n  in  1  asynchronous, active-low reset
start  in  1  one-cycle request; sampled only in IDLE
start_addr  in  ADDR_W  first RAM address to dump
length  in  ADDR_W  number of bytes to send; 0 = no-op
ram_rd_en  out  1  RAM read strobe
ram_rd_addr  out  ADDR_W  RAM read address
ram_rd_data  in  8  RAM read data, valid exactly 1 cycle after ram_rd_en
uart_tx  out  1  serial output, idle high
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse when the dump completes

Behaviour:
- Reset values (asynchronous, while Reset_n=0): uart_tx=1, busy=0, done=0, ram_rd_en=0, ram_rd_addr=0, FSM=IDLE, all counters=0.
- Reset asserted mid-frame: uart_tx goes to 1 immediately, without waiting for a clock edge. The partial frame is abandoned.
- FSM states: IDLE, RD_REQ, RD_WAIT, SEND, NEXT.
- IDLE:
  - start=1 and length≠0: latch start_addr and length, busy←1, go to RD_REQ.
  - start=1 and length=0: pulse done on the next cycle, no frame sent, busy stays 0.
- RD_REQ: ram_rd_en=1 for exactly one cycle with ram_rd_addr = current address. Go to RD_WAIT.
- RD_WAIT: capture ram_rd_data into the serialiser and assert its load. Go to SEND.
- SEND: wait for the serialiser's tx_done. Then go to NEXT.
- NEXT: decrement the remaining count and increment the address.
  - Address wraps modulo 2^ADDR_W: 0xFFFF→0x0000 for ADDR_W=16.
  - If the remaining count reaches 0: done=1 for one cycle, busy←0, go to IDLE.
  - Otherwise go to RD_REQ.
- Latency: the first start-bit falling edge on uart_tx occurs exactly 3 clocks after the cycle in which start is sampled.
- Frame timing:
  - Each bit lasts BIT_CLKS clocks.
  - Frame order: start(0), D0..D7 LSB first, stop(1). A frame is 10 bits = 4340 clocks.
  - tx_done asserts in the last clock of the stop bit.
- Inter-frame gap: the next start bit begins 3 clocks after the previous stop bit ends (NEXT, RD_REQ, RD_WAIT). uart_tx is high during the gap.
- done timing: done pulses 1 clock after the final stop bit ends. busy falls in the same cycle.
- start while busy: ignored, no queueing. The latched address and count are unaffected.
- Bit counter: the baud counter counts 0..BIT_CLKS-1. It is cleared on load so no partial first bit occurs.

Optional Feature:
- Macro: RAM_UART_DUMP_PARITY_EN.
- Defined: an even-parity bit (XOR of D0..D7) is inserted between D7 and the stop bit. The frame becomes 11 bits = 4774 clocks. All other timing is unchanged.
- Undefined: plain 8N1 as above. No parity logic is synthesised.

Decomposition:
- Shared package (or header of localparams):
  - FSM state encodings
  - BIT_CLKS computation
  - frame bit count, 10 or 11 depending on the macro
- Sub-module uart_byte_tx_core:
  - inputs Clk, Reset_n, load, data[7:0]
  - outputs uart_tx, tx_done, tx_busy
  - owns the baud counter, bit index and shift register
- The top-level module owns the FSM, address/count registers and RAM interface.

Test Plan:
1. RAM model preloaded with 0x5A,0x43,0x78 at addresses 0x0010..0x0012; start with start_addr=0x0010, length=3.
   - ram_rd_addr sequence is 0x10,0x11,0x12.
   - Decoded line bytes are 0x5A,0x43,0x78, with every bit 8680 ns at a 20 ns clock.
   - done fires once, 1 clock after the 3rd stop bit.
2. start with length=0 → done pulses 1 cycle later; uart_tx stays 1 throughout; ram_rd_en never asserts; busy stays 0.
3. start_addr=0xFFFF, length=2, RAM[0xFFFF]=0x9A, RAM[0x0000]=0xBC → addresses 0xFFFF then 0x0000; bytes 0x9A,0xBC are sent.
4. Second start pulse 1000 clocks into a 4-byte dump → ignored; exactly 4 frames are sent; a single done pulse.
5. Reset_n pulsed low for 50 ns mid-data-bit of byte 0xDE → uart_tx=1, busy=0, done=0 immediately; after release, a new start with 0xDE sends a clean full frame.
6. With RAM_UART_DUMP_PARITY_EN defined, send 0x5A → parity bit 0 and frame length 4774 clocks; send 0x43 → parity bit 1.
